input_conditioner: RTL and testbench

Two-channel input conditioner that sits directly upstream of the A/B sequence-detector FSM. It takes raw switch/button levels `raw_a` and `raw_b` and synchronizes each to `clk`. It then debounces each channel and delivers clean levels `A` and `B`, plus one-cycle rising-edge pulses, to the FSM and to any status LEDs. Both channels are identical and independent. There is no cross-channel interaction.

---
 rtl/input_conditioner_pkg.sv | 22 ++
 rtl/input_conditioner_debounce_channel.sv | 119 +++++++++++
 rtl/input_conditioner.sv | 51 +++++
 tb/tb_input_conditioner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// +----------------------------------------------------------------------+
// | input_conditioner_pkg                                                |
// | Shared debounce state encoding and default build constants.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package input_conditioner_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } db_state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage : input_conditioner_pkg

`default_nettype wire

// File: rtl/input_conditioner_debounce_channel.sv
// +----------------------------------------------------------------------+
// | debounce_channel                                                     |
// | One raw input: flop synchronizer, 4-state debounce FSM, rise pulse.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic raw,
  output logic out,
  output logic rise
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   w_s;

  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic                   out_q,   out_d;
  logic                   rise_q,  rise_d;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign w_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
    end
  end

  // The counter holds the number of agreeing samples already seen, so the
  // sample that matches at C_CNT_LAST is the DEBOUNCE_CYCLES-th one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (w_s) begin
          state_d = WAIT_HIGH;
          cnt_d   = C_CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!w_s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
          out_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + C_CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!w_s) begin
          state_d = WAIT_LOW;
          cnt_d   = C_CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (w_s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
          out_d   = 1'b0;
        end else begin
          cnt_d   = cnt_q + C_CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  assign out  = out_q;
  assign rise = rise_q;

endmodule : debounce_channel

`default_nettype wire

// File: rtl/input_conditioner.sv
// +----------------------------------------------------------------------+
// | input_conditioner                                                    |
// | Two independent synchronize-and-debounce channels (A, B).            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic raw_a,
  input  logic raw_b,
  output logic A,
  output logic B,
  output logic a_rise,
  output logic b_rise
);

  debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ch_a (
    .clk        (clk),
    .sync_reset (sync_reset),
    .raw        (raw_a),
    .out        (A),
    .rise       (a_rise)
  );

  debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ch_b (
    .clk        (clk),
    .sync_reset (sync_reset),
    .raw        (raw_b),
    .out        (B),
    .rise       (b_rise)
  );

endmodule : input_conditioner

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// +----------------------------------------------------------------------+
// | tb_input_conditioner                                                 |
// | Directed self-checking bench for input_conditioner (default params). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_input_conditioner;

  logic clk = 1'b0;
  logic sync_reset = 1'b1;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic A, B, a_rise, b_rise;

  int vecs = 0;
  int errs = 0;

  input_conditioner dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .raw_a      (raw_a),
    .raw_b      (raw_b),
    .A          (A),
    .B          (B),
    .a_rise     (a_rise),
    .b_rise     (b_rise)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs change only between ticks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sync_reset = 1'b1;
    raw_a = 1'b0;
    raw_b = 1'b0;
    tick();
    sync_reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    sync_reset = 1'b1;
    raw_a = 1'b1;
    raw_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {A, B, a_rise, b_rise};
      vecs++;
      if (obs !== 4'b0000) begin
        errs++;
        $display("FAIL reset_hold cyc=%0d {A,B,ar,br}=%b exp=0000", i, obs);
      end
    end
    sync_reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      obs = {A, B, a_rise, b_rise};
      vecs++;
      if (e < 6 && obs !== 4'b0000) begin
        errs++;
        $display("FAIL reset_release edge=%0d {A,B,ar,br}=%b exp=0000", e, obs);
      end else if (e == 6 && obs !== 4'b1111) begin
        errs++;
        $display("FAIL reset_release edge=6 {A,B,ar,br}=%b exp=1111", obs);
      end else if (e == 7 && obs !== 4'b1100) begin
        errs++;
        $display("FAIL reset_release edge=7 {A,B,ar,br}=%b exp=1100", obs);
      end
    end
  endtask

  task automatic test_clean_step();
    logic [3:0] obs;
    logic [3:0] exp;
    do_reset();
    raw_a = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = (e < 6) ? 4'b0000 : (e == 6) ? 4'b1010 : 4'b1000;
      obs = {A, B, a_rise, b_rise};
      vecs++;
      if (obs !== exp) begin
        errs++;
        $display("FAIL clean_step edge=%0d {A,B,ar,br}=%b exp=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    raw_a = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    raw_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++;
      if (A !== 1'b0 || a_rise !== 1'b0) begin
        errs++;
        $display("FAIL high_glitch cyc=%0d A=%b a_rise=%b exp A=0 a_rise=0", i, A, a_rise);
      end
    end
    raw_a = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    vecs++;
    if (A !== 1'b1) begin
      errs++;
      $display("FAIL glitch_setup A=%b exp=1", A);
    end
    raw_a = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    raw_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++;
      if (A !== 1'b1 || a_rise !== 1'b0) begin
        errs++;
        $display("FAIL low_glitch cyc=%0d A=%b a_rise=%b exp A=1 a_rise=0", i, A, a_rise);
      end
    end
  endtask

  task automatic test_bounce();
    logic [8:0] seq;
    int rises;
    seq = 9'b111101101;  // bit i is the raw_b value before edge i+1
    rises = 0;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      raw_b = (e <= 9) ? seq[e-1] : 1'b1;
      tick();
      rises += int'(b_rise);
      vecs++;
      if (B !== (e >= 11) || b_rise !== (e == 11) || A !== 1'b0) begin
        errs++;
        $display("FAIL bounce edge=%0d B=%b b_rise=%b A=%b exp B=%b b_rise=%b A=0",
                 e, B, b_rise, A, (e >= 11), (e == 11));
      end
    end
    vecs++;
    if (rises != 1) begin
      errs++;
      $display("FAIL bounce_pulses count=%0d exp=1", rises);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    raw_a = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    sync_reset = 1'b1;
    tick();
    vecs++;
    if (A !== 1'b0 || a_rise !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid A=%b a_rise=%b exp 0 0", A, a_rise);
    end
    sync_reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      vecs++;
      if (A !== (e == 6) || a_rise !== (e == 6)) begin
        errs++;
        $display("FAIL reset_mid_requal edge=%0d A=%b a_rise=%b exp %b %b",
                 e, A, a_rise, (e == 6), (e == 6));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] obs;
    do_reset();
    raw_a = 1'b1;
    raw_b = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      obs = {A, B, a_rise, b_rise};
      vecs++;
      if (obs !== ((e == 6) ? 4'b1111 : 4'b0000)) begin
        errs++;
        $display("FAIL simultaneous edge=%0d {A,B,ar,br}=%b exp=%b",
                 e, obs, (e == 6) ? 4'b1111 : 4'b0000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_reset_mid();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_input_conditioner

`default_nettype wire
